// File: rtl/timer_stamp_multi_pkg.sv
// Shared constants for the multi-channel interval timer.
// Register offsets, flag bit positions and reset defaults.
package timer_stamp_pkg;

    typedef enum logic [2:0] {
        OFF_STATUS   = 3'd0,
        OFF_CONTROL  = 3'd1,
        OFF_PERIOD_L = 3'd2,
        OFF_PERIOD_H = 3'd3,
        OFF_SNAP_L   = 3'd4,
        OFF_SNAP_H   = 3'd5,
        OFF_PRESCALE = 3'd6,
        OFF_TOCOUNT  = 3'd7
    } reg_off_e;

    localparam int BIT_TO     = 0;
    localparam int BIT_RUN    = 1;
    localparam int BIT_MISSED = 2;
    localparam int BIT_ITO    = 0;
    localparam int BIT_CONT   = 1;
    localparam int BIT_START  = 2;
    localparam int BIT_STOP   = 3;

    localparam logic [31:0] PERIOD_RST_DEF = 32'h0001_5F8F;
    localparam logic [15:0] TOCOUNT_MAX    = 16'hFFFF;

    function automatic int ch_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_stamp_multi_if.sv
// 16-bit Avalon-MM style register bus.
// AW covers the channel index plus the 3-bit register offset.
interface timer_stamp_multi_if #(
    parameter int AW = 5
);
    logic          chipselect;
    logic [AW-1:0] address;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;

    modport master (
        output chipselect,
        output address,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  address,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/timer_stamp_multi_channel.sv
// One timer channel: prescaler, down-counter, flags, snapshot,
// timeout counter and the channel's 8-word register view.
module timer_stamp_channel
    import timer_stamp_pkg::*;
#(
    parameter int          COUNT_W    = 32,
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] PERIOD_RST = PERIOD_RST_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_wr,
    input  logic [15:0] i_wdata,
    input  logic [2:0]  i_off,
    output logic [15:0] o_rdata,
    output logic        o_irq
);

    localparam int HI_W = COUNT_W - 16;
    localparam logic [COUNT_W-1:0] P_RST = PERIOD_RST[COUNT_W-1:0];

    logic [COUNT_W-1:0] r_counter;
    logic [COUNT_W-1:0] r_period;
    logic [COUNT_W-1:0] r_snap;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic [15:0]        r_to_count;
    logic               r_run;
    logic               r_to;
    logic               r_missed;
    logic               r_ito;
    logic               r_cont;
    logic               r_force;

    logic        w_start;
    logic        w_stop;
    logic        w_tick;
    logic        w_zero;
    logic        w_evt;
    logic        w_dec;
    logic        w_reload_wr;
    logic        w_wr_status;
    logic        w_wr_tocount;
    logic        w_wr_snap;
    logic [31:0] w_per32;
    logic [31:0] w_snap32;

    assign w_start      = i_wr[OFF_CONTROL] & i_wdata[BIT_START];
    assign w_stop       = i_wr[OFF_CONTROL] & i_wdata[BIT_STOP];
    assign w_wr_status  = i_wr[OFF_STATUS];
    assign w_wr_tocount = i_wr[OFF_TOCOUNT];
    assign w_wr_snap    = i_wr[OFF_SNAP_L] | i_wr[OFF_SNAP_H];
    assign w_reload_wr  = i_wr[OFF_PERIOD_L] | i_wr[OFF_PERIOD_H]
                        | i_wr[OFF_PRESCALE];

    // A pending forced reload suppresses any timeout in that cycle
    assign w_tick = r_run & (r_presc_cnt == r_presc);
    assign w_zero = (r_counter == '0);
    assign w_evt  = w_tick & w_zero & ~r_force;
    assign w_dec  = w_tick & ~w_zero & ~r_force;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter   <= P_RST;
            r_presc_cnt <= '0;
            r_run       <= 1'b0;
            r_force     <= 1'b0;
        end else begin
            r_force <= w_reload_wr;
            if (r_force | w_evt)
                r_counter <= r_period;
            else if (w_dec)
                r_counter <= r_counter - COUNT_W'(1);
            if (w_start | r_force | w_tick)
                r_presc_cnt <= '0;
            else if (r_run)
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            if (w_start)
                r_run <= 1'b1;
            else if (w_stop | r_force | (w_evt & ~r_cont))
                r_run <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= P_RST;
            r_presc  <= '0;
            r_ito    <= 1'b0;
            r_cont   <= 1'b0;
            r_snap   <= '0;
        end else begin
            if (i_wr[OFF_PERIOD_L])
                r_period[15:0] <= i_wdata;
            if (i_wr[OFF_PERIOD_H])
                r_period[COUNT_W-1:16] <= i_wdata[HI_W-1:0];
            if (i_wr[OFF_PRESCALE])
                r_presc <= i_wdata[PRESC_W-1:0];
            if (i_wr[OFF_CONTROL]) begin
                r_ito  <= i_wdata[BIT_ITO];
                r_cont <= i_wdata[BIT_CONT];
            end
            if (w_wr_snap)
                r_snap <= r_counter;
        end
    end

    // Timeout beats a simultaneous STATUS clear and leaves MISSED alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to       <= 1'b0;
            r_missed   <= 1'b0;
            r_to_count <= '0;
        end else begin
            if (w_evt) begin
                r_to <= 1'b1;
                if (r_to & ~w_wr_status)
                    r_missed <= 1'b1;
            end else if (w_wr_status) begin
                r_to     <= 1'b0;
                r_missed <= 1'b0;
            end
            if (w_wr_tocount)
                r_to_count <= w_evt ? 16'd1 : 16'd0;
            else if (w_evt && r_to_count != TOCOUNT_MAX)
                r_to_count <= r_to_count + 16'd1;
        end
    end

    assign w_per32  = 32'(r_period);
    assign w_snap32 = 32'(r_snap);
    assign o_irq    = r_to & r_ito;

    always_comb begin
        o_rdata = '0;
        unique case (reg_off_e'(i_off))
            OFF_STATUS:   o_rdata = {13'b0, r_missed, r_run, r_to};
            OFF_CONTROL:  o_rdata = {14'b0, r_cont, r_ito};
            OFF_PERIOD_L: o_rdata = w_per32[15:0];
            OFF_PERIOD_H: o_rdata = w_per32[31:16];
            OFF_SNAP_L:   o_rdata = w_snap32[15:0];
            OFF_SNAP_H:   o_rdata = w_snap32[31:16];
            OFF_PRESCALE: o_rdata = 16'(r_presc);
            OFF_TOCOUNT:  o_rdata = r_to_count;
        endcase
    end

endmodule

// File: rtl/timer_stamp_multi.sv
// Multi-channel interval timer: channel decode, registered
// read-back and interrupt reduction.
module timer_stamp_multi
    import timer_stamp_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          COUNT_W    = 32,
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] PERIOD_RST = PERIOD_RST_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_stamp_multi_if.slave   bus,
    output logic                 irq,
    output logic [NUM_CH-1:0]    irq_vec
);

    localparam int CH_AW = ch_aw(NUM_CH);

    logic              w_wen;
    logic [2:0]        w_off;
    logic [CH_AW-1:0]  w_idx;
    logic [15:0]       w_rd [NUM_CH];
    logic [15:0]       w_rsel;
    logic [15:0]       r_rdata;

    assign w_wen = bus.chipselect & ~bus.write_n;
    assign w_off = bus.address[2:0];
    assign w_idx = bus.address[CH_AW+2:3];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic       w_sel;
        logic [7:0] w_wr;

        assign w_sel = (w_idx == CH_AW'(g));
        assign w_wr  = (w_wen & w_sel) ? (8'b1 << w_off) : 8'b0;

        timer_stamp_channel #(
            .COUNT_W    (COUNT_W),
            .PRESC_W    (PRESC_W),
            .PERIOD_RST (PERIOD_RST)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_wr),
            .i_wdata (bus.writedata),
            .i_off   (w_off),
            .o_rdata (w_rd[g]),
            .o_irq   (irq_vec[g])
        );
    end

    // Unpopulated channel indices fall through to zero
    always_comb begin
        w_rsel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_idx == CH_AW'(c))
                w_rsel = w_rd[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_rdata <= '0;
        else
            r_rdata <= w_rsel;
    end

    assign bus.readdata = r_rdata;
    assign irq          = |irq_vec;

endmodule

// File: tb/tb_timer_stamp_multi.sv
// Directed bench for timer_stamp_multi: register map, timing of
// periodic / one-shot timeouts, snapshot, force reload, resets.
module tb_timer_stamp_multi;
    import timer_stamp_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       irq0, irq1;
    logic [3:0] vec0;
    logic [2:0] vec1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_stamp_multi_if #(.AW(5)) bus0 ();
    timer_stamp_multi_if #(.AW(5)) bus1 ();

    timer_stamp_multi #(.NUM_CH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus0),
        .irq(irq0), .irq_vec(vec0)
    );

    timer_stamp_multi #(.NUM_CH(3)) dut_oor (
        .clk(clk), .reset(reset), .bus(bus1),
        .irq(irq1), .irq_vec(vec1)
    );

    typedef struct {
        int          ch;
        int          off;
        logic [15:0] exp;
        string       nm;
    } rd_vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic wr(input int ch, input int off, input logic [15:0] d);
        bus0.address    = 5'(ch * 8 + off);
        bus0.writedata  = d;
        bus0.chipselect = 1'b1;
        bus0.write_n    = 1'b0;
        @(negedge clk);
        bus0.chipselect = 1'b0;
        bus0.write_n    = 1'b1;
    endtask

    task automatic rdchk(input int ch, input int off,
                         input logic [15:0] exp, input string nm);
        bus0.address    = 5'(ch * 8 + off);
        bus0.chipselect = 1'b1;
        bus0.write_n    = 1'b1;
        @(negedge clk);
        chk(nm, bus0.readdata, exp);
        bus0.chipselect = 1'b0;
    endtask

    task automatic wr1(input int ch, input int off, input logic [15:0] d);
        bus1.address    = 5'(ch * 8 + off);
        bus1.writedata  = d;
        bus1.chipselect = 1'b1;
        bus1.write_n    = 1'b0;
        @(negedge clk);
        bus1.chipselect = 1'b0;
        bus1.write_n    = 1'b1;
    endtask

    task automatic rdchk1(input int ch, input int off,
                          input logic [15:0] exp, input string nm);
        bus1.address    = 5'(ch * 8 + off);
        bus1.chipselect = 1'b1;
        bus1.write_n    = 1'b1;
        @(negedge clk);
        chk(nm, bus1.readdata, exp);
        bus1.chipselect = 1'b0;
    endtask

    task automatic wait_irq(input int ch, input int lim, output int at);
        int n = 0;
        while (!vec0[ch] && n < lim) begin
            @(negedge clk);
            n++;
        end
        at = vec0[ch] ? cyc : -1000;
    endtask

    rd_vec_t tv[10];
    int t0, t1, t2, t3;

    initial begin
        tv[0] = '{0, 0, 16'h0000, "rst st"};
        tv[1] = '{0, 1, 16'h0000, "rst ctl"};
        tv[2] = '{0, 2, 16'h5F8F, "rst perl"};
        tv[3] = '{0, 3, 16'h0001, "rst perh"};
        tv[4] = '{0, 4, 16'h0000, "rst snl"};
        tv[5] = '{0, 5, 16'h0000, "rst snh"};
        tv[6] = '{0, 6, 16'h0000, "rst presc"};
        tv[7] = '{0, 7, 16'h0000, "rst tocnt"};
        tv[8] = '{3, 2, 16'h5F8F, "rst ch3 perl"};
        tv[9] = '{3, 3, 16'h0001, "rst ch3 perh"};

        reset = 1'b1;
        bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus0.address = '0; bus0.writedata = '0;
        bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
        bus1.address = '0; bus1.writedata = '0;
        repeat (2) @(negedge clk);
        chk("rst rdata", bus0.readdata, 16'h0);
        chk("rst irq", irq0, 1'b0);
        chk("rst vec", vec0, 4'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            rdchk(tv[i].ch, tv[i].off, tv[i].exp, tv[i].nm);

        repeat (3) @(negedge clk);
        wr(0, OFF_SNAP_L, 16'h0);
        rdchk(0, OFF_SNAP_L, 16'h5F8F, "hold snl");
        rdchk(0, OFF_SNAP_H, 16'h0001, "hold snh");

        // ch1: period 9, every clock, continuous with interrupt
        wr(1, OFF_PERIOD_L, 16'd9);
        wr(1, OFF_PERIOD_H, 16'd0);
        wr(1, OFF_PRESCALE, 16'd0);
        wr(1, OFF_CONTROL, 16'h0007);
        t0 = cyc;
        wait_irq(1, 40, t1);
        chk("ch1 first", 32'(t1 - t0), 32'd10);
        chk("ch1 irq", irq0, 1'b1);
        wr(1, OFF_STATUS, 16'h0);
        wait_irq(1, 40, t2);
        chk("ch1 second", 32'(t2 - t1), 32'd10);
        wr(1, OFF_STATUS, 16'h0);
        wait_irq(1, 40, t3);
        chk("ch1 third", 32'(t3 - t2), 32'd10);
        rdchk(1, OFF_TOCOUNT, 16'd3, "ch1 tocnt");
        rdchk(1, OFF_CONTROL, 16'h0003, "ch1 ctl");
        wr(1, OFF_CONTROL, 16'h0008);
        wr(1, OFF_STATUS, 16'h0);
        chk("ch1 idle irq", irq0, 1'b0);

        // ch2: one-shot, period 4, divide by 3
        wr(2, OFF_PERIOD_L, 16'd4);
        wr(2, OFF_PERIOD_H, 16'd0);
        wr(2, OFF_PRESCALE, 16'd2);
        wr(2, OFF_CONTROL, 16'h0005);
        t0 = cyc;
        wait_irq(2, 60, t1);
        chk("ch2 oneshot", 32'(t1 - t0), 32'd15);
        rdchk(2, OFF_STATUS, 16'h0001, "ch2 st");
        repeat (20) @(negedge clk);
        rdchk(2, OFF_TOCOUNT, 16'd1, "ch2 tocnt");
        wr(2, OFF_SNAP_L, 16'h0);
        rdchk(2, OFF_SNAP_L, 16'd4, "ch2 cnt");
        wr(2, OFF_CONTROL, 16'h0);
        wr(2, OFF_STATUS, 16'h0);

        // ch0: period 0 continuous, timeout every clock
        wr(0, OFF_PERIOD_L, 16'd0);
        wr(0, OFF_PERIOD_H, 16'd0);
        wr(0, OFF_PRESCALE, 16'd0);
        wr(0, OFF_CONTROL, 16'h0007);
        repeat (3) @(negedge clk);
        rdchk(0, OFF_STATUS, 16'h0007, "ch0 missed");
        wr(0, OFF_STATUS, 16'h0);
        rdchk(0, OFF_STATUS, 16'h0007, "ch0 st vs evt");
        wr(0, OFF_TOCOUNT, 16'h0);
        rdchk(0, OFF_TOCOUNT, 16'd1, "ch0 tocnt vs evt");
        wr(0, OFF_CONTROL, 16'h0008);
        wr(0, OFF_STATUS, 16'h0);
        rdchk(0, OFF_STATUS, 16'h0000, "ch0 stopped");

        // ch3: free-running from reset period, then snapshot
        wr(3, OFF_CONTROL, 16'h0006);
        repeat (5) @(negedge clk);
        wr(3, OFF_SNAP_L, 16'h0);
        rdchk(3, OFF_SNAP_L, 16'h5F8A, "ch3 snl");
        rdchk(3, OFF_SNAP_H, 16'h0001, "ch3 snh");

        // force reload from a period write mid-count
        wr(3, OFF_PERIOD_L, 16'h0020);
        rdchk(3, OFF_STATUS, 16'h0002, "ch3 run +1");
        rdchk(3, OFF_STATUS, 16'h0000, "ch3 run +2");
        wr(3, OFF_SNAP_L, 16'h0);
        rdchk(3, OFF_SNAP_L, 16'h0020, "ch3 reload l");
        rdchk(3, OFF_SNAP_H, 16'h0001, "ch3 reload h");
        chk("vec idle", vec0, 4'h0);

        // out-of-range channel on a 3-channel instance
        rdchk1(3, OFF_PERIOD_L, 16'h0, "oor rd");
        wr1(3, OFF_PERIOD_L, 16'h1234);
        wr1(3, OFF_CONTROL, 16'h0005);
        rdchk1(0, OFF_PERIOD_L, 16'h5F8F, "oor ch0");
        rdchk1(1, OFF_PERIOD_L, 16'h5F8F, "oor ch1");
        rdchk1(2, OFF_PERIOD_L, 16'h5F8F, "oor ch2");
        rdchk1(2, OFF_STATUS, 16'h0, "oor ch2 st");
        rdchk1(3, OFF_STATUS, 16'h0, "oor st");

        // asynchronous reset in the middle of a low phase
        wr(0, OFF_CONTROL, 16'h0007);
        repeat (2) @(negedge clk);
        chk("pre rst irq", irq0, 1'b1);
        bus0.address = 5'(OFF_STATUS);
        @(negedge clk);
        chk("pre rst rd", bus0.readdata, 16'h0007);
        #2 reset = 1'b1;
        #1;
        chk("async rdata", bus0.readdata, 16'h0);
        chk("async irq", irq0, 1'b0);
        chk("async vec", vec0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        rdchk(0, OFF_PERIOD_L, 16'h5F8F, "post rst perl");
        rdchk(0, OFF_STATUS, 16'h0000, "post rst st");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
